// File: rtl/rename_alias_table_pkg.sv
// ---------------------------------------------------------------------------
// rename_alias_table_pkg
// Shared sizes and types for the register alias table (RAT).
//   MACHINE_WIDTH : instructions renamed per cycle
//   ISSUE_WIDTH   : retire slots per cycle
//   CREG_AW       : architectural register address width (GPR, HI, LO, CP0)
//   PREG_AW       : ROB tag width
//   rat_entry_t   : one table entry / one lookup result {valid, id}
//   rename_info_t : per-slot lookup results for src1, src2 and dst
// ---------------------------------------------------------------------------
package rename_alias_table_pkg;

    localparam int MACHINE_WIDTH = 2;
    localparam int ISSUE_WIDTH   = 2;
    localparam int CREG_AW       = 7;
    localparam int PREG_AW       = 6;
    localparam int CREG_NUM      = 1 << CREG_AW;

    typedef logic [CREG_AW-1:0] creg_addr_t;
    typedef logic [PREG_AW-1:0] preg_addr_t;

    typedef struct packed {
        logic       valid;
        preg_addr_t id;
    } rat_entry_t;

    typedef struct packed {
        rat_entry_t src1;
        rat_entry_t src2;
        rat_entry_t dst;
    } rename_info_t;

endpackage

// File: rtl/rename_alias_table_if.sv
// ---------------------------------------------------------------------------
// rename_alias_table_if
// Rename-stage / ROB / retire-bus signals seen by the RAT.
//   master : rename stage side (drives the instruction group, new tags,
//            stall/flush and the retire bus; receives lookup results)
//   slave  : the RAT itself
// Multi-slot fields are flat vectors, slot i at [i*W +: W].
// ---------------------------------------------------------------------------
interface rename_alias_table_if;
    import rename_alias_table_pkg::*;

    logic                               stall;
    logic                               flush;
    logic [MACHINE_WIDTH-1:0]           instr_valid;
    logic [MACHINE_WIDTH*CREG_AW-1:0]   instr_src1;
    logic [MACHINE_WIDTH*CREG_AW-1:0]   instr_src2;
    logic [MACHINE_WIDTH*CREG_AW-1:0]   instr_dst;
    logic [MACHINE_WIDTH*PREG_AW-1:0]   rob_addr_new;
    logic [MACHINE_WIDTH-1:0]           src1_valid;
    logic [MACHINE_WIDTH*PREG_AW-1:0]   src1_id;
    logic [MACHINE_WIDTH-1:0]           src2_valid;
    logic [MACHINE_WIDTH*PREG_AW-1:0]   src2_id;
    logic [MACHINE_WIDTH-1:0]           dst_valid;
    logic [MACHINE_WIDTH*PREG_AW-1:0]   dst_id;
    logic [ISSUE_WIDTH-1:0]             retire_valid;
    logic [ISSUE_WIDTH*CREG_AW-1:0]     retire_dst;
    logic [ISSUE_WIDTH*PREG_AW-1:0]     retire_preg;

    modport master (
        output stall, flush, instr_valid, instr_src1, instr_src2, instr_dst,
               rob_addr_new, retire_valid, retire_dst, retire_preg,
        input  src1_valid, src1_id, src2_valid, src2_id, dst_valid, dst_id
    );

    modport slave (
        input  stall, flush, instr_valid, instr_src1, instr_src2, instr_dst,
               rob_addr_new, retire_valid, retire_dst, retire_preg,
        output src1_valid, src1_id, src2_valid, src2_id, dst_valid, dst_id
    );

endinterface

// File: rtl/rename_alias_table_bypass.sv
// ---------------------------------------------------------------------------
// rename_alias_table_bypass
// Combinational lookup of one architectural address for one slot.
//   slot_valid  : the slot doing the lookup is valid
//   addr        : architectural address to resolve
//   older_valid : instr_valid masked to the slots older than this one
//   group_dst   : destinations of the whole group
//   group_tag   : ROB tags allocated to the whole group
//   table_entry : registered table entry for addr
//   result      : {valid, id} of the producer of addr
// ---------------------------------------------------------------------------
module rename_alias_table_bypass
    import rename_alias_table_pkg::*;
(
    input  logic                             slot_valid,
    input  creg_addr_t                       addr,
    input  logic [MACHINE_WIDTH-1:0]         older_valid,
    input  logic [MACHINE_WIDTH*CREG_AW-1:0] group_dst,
    input  logic [MACHINE_WIDTH*PREG_AW-1:0] group_tag,
    input  rat_entry_t                       table_entry,
    output rat_entry_t                       result
);

    always_comb begin
        result = '0;
        if (slot_valid && addr != '0) begin
            // An invalid entry reports id 0, its tag bits are stale.
            result.valid = table_entry.valid;
            result.id    = table_entry.valid ? table_entry.id : '0;
            // Ascending scan: the youngest older writer is the last to hit.
            for (int j = 0; j < MACHINE_WIDTH; j++) begin
                if (older_valid[j] && group_dst[j*CREG_AW +: CREG_AW] == addr) begin
                    result.valid = 1'b1;
                    result.id    = group_tag[j*PREG_AW +: PREG_AW];
                end
            end
        end
    end

endmodule

// File: rtl/rename_alias_table.sv
// ---------------------------------------------------------------------------
// rename_alias_table
// Register alias table: maps each architectural register to the ROB entry
// that will produce it. Lookups are combinational against the table as
// registered at the start of the cycle; rename writes, retire clears and
// flush take effect at the clock edge.
//   clk    : clock
//   resetn : asynchronous active-low reset, clears every valid bit
//   rn     : rename/ROB/retire interface (slave side)
// ---------------------------------------------------------------------------
module rename_alias_table
    import rename_alias_table_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    rename_alias_table_if.slave  rn
);

    logic       entry_valid [CREG_NUM];
    preg_addr_t entry_tag   [CREG_NUM];

    rename_info_t info [MACHINE_WIDTH];

    creg_addr_t ren_dst [MACHINE_WIDTH];
    preg_addr_t ren_tag [MACHINE_WIDTH];
    logic       ren_we  [MACHINE_WIDTH];

    creg_addr_t ret_dst [ISSUE_WIDTH];
    logic       ret_clr [ISSUE_WIDTH];

    // Lookup: three resolvers per slot, each seeing only older slots.
    for (genvar s = 0; s < MACHINE_WIDTH; s++) begin : g_slot
        localparam logic [MACHINE_WIDTH-1:0] OLDER_MASK = MACHINE_WIDTH'((1 << s) - 1);

        creg_addr_t                a_src1, a_src2, a_dst;
        logic [MACHINE_WIDTH-1:0]  older;
        rat_entry_t                e_src1, e_src2, e_dst;

        assign a_src1 = rn.instr_src1[s*CREG_AW +: CREG_AW];
        assign a_src2 = rn.instr_src2[s*CREG_AW +: CREG_AW];
        assign a_dst  = rn.instr_dst [s*CREG_AW +: CREG_AW];
        assign older  = rn.instr_valid & OLDER_MASK;

        assign e_src1 = {entry_valid[a_src1], entry_tag[a_src1]};
        assign e_src2 = {entry_valid[a_src2], entry_tag[a_src2]};
        assign e_dst  = {entry_valid[a_dst],  entry_tag[a_dst]};

        rename_alias_table_bypass u_src1 (
            .slot_valid  (rn.instr_valid[s]),
            .addr        (a_src1),
            .older_valid (older),
            .group_dst   (rn.instr_dst),
            .group_tag   (rn.rob_addr_new),
            .table_entry (e_src1),
            .result      (info[s].src1)
        );

        rename_alias_table_bypass u_src2 (
            .slot_valid  (rn.instr_valid[s]),
            .addr        (a_src2),
            .older_valid (older),
            .group_dst   (rn.instr_dst),
            .group_tag   (rn.rob_addr_new),
            .table_entry (e_src2),
            .result      (info[s].src2)
        );

        rename_alias_table_bypass u_dst (
            .slot_valid  (rn.instr_valid[s]),
            .addr        (a_dst),
            .older_valid (older),
            .group_dst   (rn.instr_dst),
            .group_tag   (rn.rob_addr_new),
            .table_entry (e_dst),
            .result      (info[s].dst)
        );
    end

    always_comb begin
        rn.src1_valid = '0;
        rn.src1_id    = '0;
        rn.src2_valid = '0;
        rn.src2_id    = '0;
        rn.dst_valid  = '0;
        rn.dst_id     = '0;
        for (int s = 0; s < MACHINE_WIDTH; s++) begin
            rn.src1_valid[s]                = info[s].src1.valid;
            rn.src1_id[s*PREG_AW +: PREG_AW] = info[s].src1.id;
            rn.src2_valid[s]                = info[s].src2.valid;
            rn.src2_id[s*PREG_AW +: PREG_AW] = info[s].src2.id;
            rn.dst_valid[s]                 = info[s].dst.valid;
            rn.dst_id[s*PREG_AW +: PREG_AW]  = info[s].dst.id;
        end
    end

    // Write enables, all decided from the pre-update table.
    always_comb begin
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
            ren_dst[i] = rn.instr_dst[i*CREG_AW +: CREG_AW];
            ren_tag[i] = rn.rob_addr_new[i*PREG_AW +: PREG_AW];
            ren_we[i]  = rn.instr_valid[i] && !rn.stall && ren_dst[i] != '0;
        end
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            ret_dst[k] = rn.retire_dst[k*CREG_AW +: CREG_AW];
            // A tag mismatch means a younger producer owns the register.
            ret_clr[k] = rn.retire_valid[k] && ret_dst[k] != '0
                         && entry_valid[ret_dst[k]]
                         && entry_tag[ret_dst[k]] == rn.retire_preg[k*PREG_AW +: PREG_AW];
        end
    end

    // Valid bits: flush beats everything; rename writes are issued after
    // retire clears so a same-cycle rename of the same register wins, and
    // the ascending slot loop lets the highest slot win among renames.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < CREG_NUM; r++) entry_valid[r] <= 1'b0;
        end else if (rn.flush) begin
            for (int r = 0; r < CREG_NUM; r++) entry_valid[r] <= 1'b0;
        end else begin
            for (int k = 0; k < ISSUE_WIDTH; k++) begin
                if (ret_clr[k]) entry_valid[ret_dst[k]] <= 1'b0;
            end
            for (int i = 0; i < MACHINE_WIDTH; i++) begin
                if (ren_we[i]) entry_valid[ren_dst[i]] <= 1'b1;
            end
        end
    end

    // Tags carry no reset; they are meaningless while the valid bit is low.
    always_ff @(posedge clk) begin
        if (!rn.flush) begin
            for (int i = 0; i < MACHINE_WIDTH; i++) begin
                if (ren_we[i]) entry_tag[ren_dst[i]] <= ren_tag[i];
            end
        end
    end

endmodule

// File: tb/tb_rename_alias_table.sv
// ---------------------------------------------------------------------------
// tb_rename_alias_table
// Directed vectors for the register alias table. Each vector drives one
// cycle of inputs and queues the hand-computed lookup outputs; a monitor
// on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_rename_alias_table;
    import rename_alias_table_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    rename_alias_table_if rif ();

    rename_alias_table dut (
        .clk    (clk),
        .resetn (resetn),
        .rn     (rif)
    );

    typedef struct {
        string       name;
        logic [41:0] exp;
    } sb_t;

    sb_t sb_q[$];
    sb_t cur;
    int  n_vec = 0;
    int  n_bad = 0;
    logic [41:0] act;

    // Expected output word: {src1_valid, src1_id, src2_valid, src2_id, dst_valid, dst_id},
    // each id field ordered {slot1, slot0}.
    function automatic logic [41:0] E(
        input logic [1:0] s1v, input logic [5:0] s1i1, input logic [5:0] s1i0,
        input logic [1:0] s2v, input logic [5:0] s2i1, input logic [5:0] s2i0,
        input logic [1:0] dv,  input logic [5:0] di1,  input logic [5:0] di0
    );
        return {s1v, s1i1, s1i0, s2v, s2i1, s2i0, dv, di1, di0};
    endfunction

    // Monitor: compare once per queued vector, mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            act = {rif.src1_valid, rif.src1_id, rif.src2_valid, rif.src2_id,
                   rif.dst_valid, rif.dst_id};
            n_vec++;
            if (act !== cur.exp) begin
                n_bad++;
                $display("FAIL %s: got %h, expected %h", cur.name, act, cur.exp);
            end
        end
    end

    task automatic vec(
        input string      nm,
        input logic       rst_mid,
        input logic       stl,
        input logic       fl,
        input logic [1:0] iv,
        input logic [6:0] a1_0, input logic [6:0] a2_0, input logic [6:0] d_0, input logic [5:0] t_0,
        input logic [6:0] a1_1, input logic [6:0] a2_1, input logic [6:0] d_1, input logic [5:0] t_1,
        input logic [1:0] rv,
        input logic [6:0] rd_0, input logic [5:0] rp_0,
        input logic [6:0] rd_1, input logic [5:0] rp_1,
        input logic [41:0] e
    );
        sb_t item;
        @(posedge clk);
        #1;
        resetn           = 1'b1;
        rif.stall        = stl;
        rif.flush        = fl;
        rif.instr_valid  = iv;
        rif.instr_src1   = {a1_1, a1_0};
        rif.instr_src2   = {a2_1, a2_0};
        rif.instr_dst    = {d_1, d_0};
        rif.rob_addr_new = {t_1, t_0};
        rif.retire_valid = rv;
        rif.retire_dst   = {rd_1, rd_0};
        rif.retire_preg  = {rp_1, rp_0};
        if (rst_mid) resetn = 1'b0;
        item.name = nm;
        item.exp  = e;
        sb_q.push_back(item);
    endtask

    localparam logic [41:0] Z = 42'd0;

    initial begin
        rif.stall        = 1'b0;
        rif.flush        = 1'b0;
        rif.instr_valid  = '0;
        rif.instr_src1   = '0;
        rif.instr_src2   = '0;
        rif.instr_dst    = '0;
        rif.rob_addr_new = '0;
        rif.retire_valid = '0;
        rif.retire_dst   = '0;
        rif.retire_preg  = '0;
        repeat (2) @(posedge clk);

        //   name                     rst s  f  iv     slot0: s1 s2 d  t   slot1: s1 s2 d  t   rv     r0      r1      expected
        vec("reset_lookup",          0, 0, 0, 2'b01,  5, 0, 5, 3,   0, 0, 0, 0,  2'b00, 0, 0,   0, 0,   Z);
        vec("r5_mapped",             0, 0, 0, 2'b01,  5, 5, 0, 0,   0, 0, 0, 0,  2'b00, 0, 0,   0, 0,   E(2'b01,0,3, 2'b01,0,3, 2'b00,0,0));
        vec("group_bypass",          0, 0, 0, 2'b11,  0, 0, 8, 10,  5, 8, 8, 11, 2'b00, 0, 0,   0, 0,   E(2'b10,3,0, 2'b10,10,0, 2'b10,10,0));
        vec("r8_highest_slot",       0, 0, 0, 2'b01,  8, 0, 0, 0,   5, 0, 0, 0,  2'b00, 0, 0,   0, 0,   E(2'b01,0,11, 2'b00,0,0, 2'b00,0,0));
        vec("map_r9_t4",             0, 0, 0, 2'b01,  9, 0, 9, 4,   0, 0, 0, 0,  2'b00, 0, 0,   0, 0,   Z);
        vec("map_r9_t7",             0, 0, 0, 2'b01,  9, 0, 9, 7,   0, 0, 0, 0,  2'b00, 0, 0,   0, 0,   E(2'b01,0,4, 2'b00,0,0, 2'b01,0,4));
        vec("retire_r9_stale",       0, 0, 0, 2'b01,  9, 0, 0, 0,   0, 0, 0, 0,  2'b01, 9, 4,   0, 0,   E(2'b01,0,7, 2'b00,0,0, 2'b00,0,0));
        vec("retire_r9_owner",       0, 0, 0, 2'b01,  9, 0, 0, 0,   0, 0, 0, 0,  2'b01, 9, 7,   0, 0,   E(2'b01,0,7, 2'b00,0,0, 2'b00,0,0));
        vec("r9_cleared",            0, 0, 0, 2'b01,  9, 0, 0, 0,   0, 0, 0, 0,  2'b00, 0, 0,   0, 0,   Z);
        vec("map_r12_t2",            0, 0, 0, 2'b01,  0, 0, 12, 2,  0, 0, 0, 0,  2'b00, 0, 0,   0, 0,   Z);
        vec("retire_vs_rename_r12",  0, 0, 0, 2'b01,  12, 0, 12, 6, 0, 0, 0, 0,  2'b01, 12, 2,  0, 0,   E(2'b01,0,2, 2'b00,0,0, 2'b01,0,2));
        vec("r12_rename_wins",       0, 0, 0, 2'b01,  12, 0, 0, 0,  0, 0, 0, 0,  2'b00, 0, 0,   0, 0,   E(2'b01,0,6, 2'b00,0,0, 2'b00,0,0));
        vec("stall_r3",              0, 1, 0, 2'b01,  3, 0, 3, 1,   0, 0, 0, 0,  2'b01, 12, 6,  0, 0,   Z);
        vec("stall_effects",         0, 0, 0, 2'b11,  3, 0, 0, 0,   12, 0, 0, 0, 2'b00, 0, 0,   0, 0,   Z);
        vec("pre_flush_map",         0, 0, 0, 2'b11,  0, 0, 20, 5,  0, 0, 21, 9, 2'b00, 0, 0,   0, 0,   Z);
        vec("flush_with_rename",     0, 0, 1, 2'b11,  20, 0, 22, 12, 21, 0, 0, 0, 2'b00, 0, 0,  0, 0,   E(2'b11,9,5, 2'b00,0,0, 2'b00,0,0));
        vec("after_flush",           0, 0, 0, 2'b11,  20, 22, 0, 0, 21, 5, 8, 0, 2'b00, 0, 0,   0, 0,   Z);
        vec("dst_zero_group",        0, 0, 0, 2'b11,  0, 0, 0, 7,   0, 0, 0, 8,  2'b00, 0, 0,   0, 0,   Z);
        vec("src_zero_lookup",       0, 0, 0, 2'b11,  0, 0, 0, 0,   0, 0, 0, 0,  2'b00, 0, 0,   0, 0,   Z);
        vec("map_r30",               0, 0, 0, 2'b01,  0, 0, 30, 13, 0, 0, 0, 0,  2'b00, 0, 0,   0, 0,   Z);
        vec("r30_mapped",            0, 0, 0, 2'b01,  30, 0, 0, 0,  0, 0, 0, 0,  2'b00, 0, 0,   0, 0,   E(2'b01,0,13, 2'b00,0,0, 2'b00,0,0));
        vec("async_reset",           1, 0, 0, 2'b01,  30, 0, 0, 0,  0, 0, 0, 0,  2'b00, 0, 0,   0, 0,   Z);
        vec("post_reset_map_r40",    0, 0, 0, 2'b01,  30, 0, 40, 20, 0, 0, 0, 0, 2'b00, 0, 0,   0, 0,   Z);
        vec("dual_retire_r40",       0, 0, 0, 2'b01,  40, 0, 0, 0,  0, 0, 0, 0,  2'b11, 40, 20, 40, 21, E(2'b01,0,20, 2'b00,0,0, 2'b00,0,0));
        vec("r40_cleared",           0, 0, 0, 2'b01,  40, 0, 0, 0,  0, 0, 0, 0,  2'b00, 0, 0,   0, 0,   Z);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d vectors unchecked, expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
